reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Sequential reader for the CPU's 32-bit register bank: on request, steps through a contiguous address range and presents each word on a valid/ready stream.
- Consumer is the debug display/serial path.
- Sits beside the register file, on its spare read port; never writes the bank.
- Bank read port is synchronous: data for an address presented in cycle N is valid in cycle N+1.

Parameters:
- DATA_W, 32, width of a register word.
- ADDR_W, 5, register address width.
- FIRST_ADDR, 0, first address dumped.
- LAST_ADDR, 31, last address dumped; must satisfy FIRST_ADDR <= LAST_ADDR <= 2^ADDR_W-1.

Ports:
- clk  input  1  clock, all state on rising edge.
- clear  input  1  synchronous active-low reset; sampled on rising clk; low = reset.
- start  input  1  pulse; begins a dump when idle.
- abort  input  1  terminates a dump in progress.
- rd_addr  output  ADDR_W  address to register-bank read port.
- rd_en  output  1  read strobe to bank.
- rd_data  input  DATA_W  bank read data, valid the cycle after rd_en.
- out_valid  output  1  out_data/out_index hold a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  captured register word.
- out_index  output  ADDR_W  address the word came from.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (clear low at a rising edge): state IDLE; rd_addr=FIRST_ADDR, rd_en=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0. Reset overrides every other input, including mid-dump; a pending word is dropped.
- IDLE:
  - start=1 -> READ; rd_addr=FIRST_ADDR, rd_en=1, busy=1 on the next cycle.
  - start while busy is ignored.
- READ (1 cycle):
  - rd_en=1, addressed to the bank.
  - Next state WAIT; rd_en drops to 0.
- WAIT (1 cycle):
  - Captures rd_data into out_data and rd_addr into out_index.
  - out_valid=1 from the next cycle; next state PRESENT.
- PRESENT:
  - out_data, out_index and out_valid stay stable until out_valid & out_ready.
  - Transfer with out_index!=LAST_ADDR: out_valid=0, rd_addr+1, next state READ.
  - Transfer with out_index==LAST_ADDR: out_valid=0, next state DONE.
  - out_ready may be held high permanently. Transfer-to-next-transfer spacing is then 3 cycles (READ, WAIT, PRESENT).
- DONE (1 cycle): done=1, busy=0 from the next cycle; returns to IDLE. start in this cycle is ignored.
- Latency: start at edge N -> first out_valid high in cycle N+3.
- Address arithmetic:
  - rd_addr increments by 1 only; it never wraps past LAST_ADDR.
  - FIRST_ADDR==LAST_ADDR gives exactly one word.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, out_valid=0, busy=0, done stays 0.
  - A transfer coinciding with abort counts as consumed; no further words follow.
  - abort has priority over start and out_ready.
- busy=1 in READ, WAIT and PRESENT; 0 in IDLE and DONE.
- out_data and out_index retain their last value when out_valid=0.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Full dump:
  - Stimulus: bank preloaded reg[i]=0x1000_0000+i; start pulse; out_ready=1.
  - Required: 32 words, index 0..31, data 0x1000_0000..0x1000_001F, in order; done pulses once, 1 cycle after the index-31 transfer; busy falls the same cycle done rises.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles on word 5.
  - Required: out_valid stays 1 with out_data=0x1000_0005 and out_index=5 unchanged; exactly one word for index 5 delivered; no skipped or duplicated index.
- Abort mid-dump:
  - Stimulus: abort asserted while in PRESENT with index 12.
  - Required: next cycle out_valid=0, busy=0, done never pulses; a later start restarts from index 0.
- Reset mid-dump:
  - Stimulus: clear driven low for 1 cycle while in WAIT at index 7.
  - Required: all outputs at reset values next cycle; no word for index 7 appears.
- Single-entry range and start while busy:
  - Stimulus: FIRST_ADDR=LAST_ADDR=31, reg31=0xDEAD_BEEF; extra start pulses during the dump.
  - Required: exactly one word 0xDEAD_BEEF at index 31; one done pulse; extra starts have no effect.
- Timing:
  - Stimulus: start at edge N, out_ready tied 1.
  - Required: rd_en=1 in cycle N+1 only; out_valid=1 in cycle N+3; next rd_en in cycle N+4.

Source files
------------

// File: rtl/reg_dump_reader_if.sv
// ---------------------------------------------------------------------------
// reg_dump_reader_if
// Bundles the two buses of the register dump reader:
//   - bank read port : rd_addr / rd_en toward the register bank, rd_data back
//                      (data returns the cycle after rd_en)
//   - word stream    : out_valid / out_ready handshake carrying out_data and
//                      out_index toward the debug display/serial path
// master modport : the reader (drives the read port and the stream)
// slave modport  : bank + consumer side (drives rd_data and out_ready)
// ---------------------------------------------------------------------------
interface reg_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output rd_addr,
    output rd_en,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index
  );

endinterface

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
// Walks the register bank from FIRST_ADDR to LAST_ADDR through its spare
// synchronous read port and hands each word to the debug path on a
// valid/ready stream. Read-only toward the bank.
//
// Ports:
//   clk    - clock, all state on rising edge
//   clear  - synchronous active-low reset
//   start  - begins a dump when idle (ignored while busy or in the done cycle)
//   abort  - ends a dump in progress; wins over start and out_ready
//   bus    - master side of reg_dump_reader_if (bank read port + word stream)
//   busy   - high in READ, WAIT and PRESENT
//   done   - one-cycle pulse after the last word is accepted
//
// Per word the sequence is READ (strobe bank) -> WAIT (bank data arrives,
// captured) -> PRESENT (hold until accepted), so with out_ready tied high a
// word is transferred every 3 cycles. All outputs are registers; out_ready
// only affects state through the sequential block.
// ---------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 abort,
  reg_dump_reader_if.master    bus,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_en_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ADDR_W-1:0] out_index_r;
  logic              busy_r;
  logic              done_r;

  // Dump sequencer: state, bank read strobe, captured word and status flags
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r     <= ST_IDLE;
      rd_addr_r   <= FIRST_A;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_index_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (abort && (state_r != ST_IDLE)) begin
      // Any pending word is dropped; a transfer in this same cycle has
      // already been seen by the consumer and counts as consumed.
      state_r     <= ST_IDLE;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start && !abort) begin
            state_r   <= ST_READ;
            rd_addr_r <= FIRST_A;
            rd_en_r   <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          state_r <= ST_WAIT;
          rd_en_r <= 1'b0;
        end
        ST_WAIT: begin
          // Bank data for the address strobed in READ is valid now.
          out_data_r  <= bus.rd_data;
          out_index_r <= rd_addr_r;
          out_valid_r <= 1'b1;
          state_r     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (out_index_r == LAST_A) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              // Only reached below LAST_ADDR, so the address never wraps.
              rd_addr_r <= rd_addr_r + ONE_A;
              rd_en_r   <= 1'b1;
              state_r   <= ST_READ;
            end
          end else begin
            state_r <= ST_PRESENT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          rd_en_r     <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr   = rd_addr_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = out_index_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
// Scoreboard bench: when a start is accepted the reference model pushes the
// whole expected word list (index, bank contents) for the address range; a
// negedge monitor pops and compares on every handshake, checks the done
// pulse and hold-under-backpressure. A second instance covers the
// single-entry range (31..31).
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int FIRST = 0;
  localparam int LAST  = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear, start, abort, busy, done;
  logic start2, abort2, busy2, done2;

  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_ADDR(FIRST), .LAST_ADDR(LAST)) dut (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .bus(bus), .busy(busy), .done(done)
  );

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_ADDR(31), .LAST_ADDR(31)) dut2 (
    .clk(clk), .clear(clear), .start(start2), .abort(abort2),
    .bus(bus2), .busy(busy2), .done(done2)
  );

  logic [DW-1:0] bank  [0:31];
  logic [DW-1:0] bank2 [0:31];

  // synchronous bank read ports
  always @(posedge clk) if (bus.rd_en)  bus.rd_data  <= bank[bus.rd_addr];
  always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= bank2[bus2.rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  word_t exp_q[$];
  bit    m_active   = 1'b0;
  bit    exp_done   = 1'b0;
  int    words_seen = 0;
  int    done_seen  = 0;
  bit    prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_clear = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  always @(negedge clk) begin : monitor
    bit    was_active, xfer, nxt_done;
    word_t e;
    was_active = m_active;
    nxt_done   = 1'b0;
    xfer       = bus.out_valid && bus.out_ready;
    chk("done", done, exp_done);
    if (done) done_seen++;
    if (exp_done) chk("busy_in_done", busy, 0);
    if (prev_valid && !prev_ready && !prev_abort && prev_clear) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, prev_data);
      chk("hold_index", bus.out_index, prev_idx);
    end
    if (!clear) begin
      exp_q.delete();
      m_active = 1'b0;
    end else begin
      if (xfer) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: got index %0d data 0x%08h, required no word", bus.out_index, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_index", bus.out_index, e.idx);
          chk("word_data", bus.out_data, e.data);
          chk("busy_xfer", busy, 1);
          if (exp_q.size() == 0) begin
            m_active = 1'b0;
            nxt_done = !abort;
          end
        end
      end
      if (was_active && abort) begin
        exp_q.delete();
        m_active = 1'b0;
        nxt_done = 1'b0;
      end else if (!was_active && !exp_done && start && !abort) begin
        for (int i = FIRST; i <= LAST; i++) begin
          e.idx  = AW'(i);
          e.data = bank[i];
          exp_q.push_back(e);
        end
        m_active = 1'b1;
      end
    end
    exp_done   = nxt_done;
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_abort = abort;
    prev_clear = clear;
    prev_data  = bus.out_data;
    prev_idx   = bus.out_index;
  end

  // second instance: simple counters
  int cnt2 = 0, dcnt2 = 0;
  logic [DW-1:0] data2 = '0;
  logic [AW-1:0] idx2  = '0;
  always @(negedge clk) begin
    if (clear && bus2.out_valid && bus2.out_ready) begin
      cnt2++;
      data2 = bus2.out_data;
      idx2  = bus2.out_index;
    end
    if (done2) dcnt2++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(posedge clk);
      if (!m_active && !exp_done) begin ok = 1'b1; break; end
    end
    #1;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: dump still running after %0d cycles, required idle", name, max);
    end
  endtask

  task automatic wait_read(input string name, input int a, input int max);
    bit ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(posedge clk); #1;
      if (bus.rd_en && (bus.rd_addr == AW'(a))) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no read of address %0d within %0d cycles", name, a, max);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w0, d0;

  initial begin
    clear = 1'b0; start = 1'b0; abort = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bank[i]  = 32'h1000_0000 + 32'(i);
      bank2[i] = $urandom;
    end
    bank2[31] = 32'hDEAD_BEEF;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", bus.rd_addr, FIRST);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst2_rd_addr", bus2.rd_addr, 31);
    clear = 1'b1;

    // single-entry range with extra starts through READ..DONE
    @(posedge clk); #1 start2 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    start2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("single_count", cnt2, 1);
    chk("single_data", data2, 32'hDEAD_BEEF);
    chk("single_index", idx2, 31);
    chk("single_done_count", dcnt2, 1);
    chk("single_busy_end", busy2, 0);

    // full dump with timing checks
    w0 = words_seen; d0 = done_seen;
    pulse_start();
    @(negedge clk);
    chk("t1_rd_en", bus.rd_en, 1);
    chk("t1_rd_addr", bus.rd_addr, 0);
    chk("t1_busy", busy, 1);
    chk("t1_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t2_rd_en", bus.rd_en, 0);
    chk("t2_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_out_index", bus.out_index, 0);
    chk("t3_out_data", bus.out_data, 32'h1000_0000);
    @(negedge clk);
    chk("t4_rd_en", bus.rd_en, 1);
    chk("t4_rd_addr", bus.rd_addr, 1);
    chk("t4_out_valid", bus.out_valid, 0);
    wait_idle("full_dump", 400);
    chk("full_words", words_seen - w0, 32);
    chk("full_done_pulses", done_seen - d0, 1);

    // backpressure on word 5
    w0 = words_seen;
    pulse_start();
    wait_read("bp_read5", 5, 100);
    bus.out_ready = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 32'h1000_0005);
    chk("bp_index", bus.out_index, 5);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_idle("bp_dump", 400);
    chk("bp_words", words_seen - w0, 32);

    // abort while presenting index 12
    w0 = words_seen; d0 = done_seen;
    pulse_start();
    wait_read("ab_read12", 12, 100);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ab_presenting", bus.out_valid, 1);
    chk("ab_present_idx", bus.out_index, 12);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    bus.out_ready = 1'b1;
    chk("ab_out_valid", bus.out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("ab_words", words_seen - w0, 12);
    chk("ab_no_done", done_seen - d0, 0);

    // reset while in WAIT at index 7 (restart also checks index 0 first)
    w0 = words_seen;
    pulse_start();
    wait_read("rs_read7", 7, 100);
    @(posedge clk); #1 clear = 1'b0;
    @(posedge clk); #1;
    chk("rs_rd_addr", bus.rd_addr, FIRST);
    chk("rs_rd_en", bus.rd_en, 0);
    chk("rs_out_valid", bus.out_valid, 0);
    chk("rs_out_data", bus.out_data, 0);
    chk("rs_out_index", bus.out_index, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    clear = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rs_words", words_seen - w0, 7);

    // randomized dumps: random data, random backpressure, later random aborts
    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < 32; i++) bank[i] = $urandom;
      bus.out_ready = 1'b1;
      pulse_start();
      begin
        bit ok = 1'b0;
        for (int k = 0; k < 1500; k++) begin
          @(posedge clk); #1;
          if (!m_active && !exp_done) begin ok = 1'b1; break; end
          bus.out_ready = ($urandom_range(0, 9) < 7);
          abort = (d >= 3) && ($urandom_range(0, 59) == 0);
        end
        abort = 1'b0;
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_dump_%0d: not idle within 1500 cycles", d);
        end
      end
      repeat (3) @(posedge clk);
    end

    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
